mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_access_if.sv | 23 ++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access controller: FSM states, access modes
// and bus widths, plus small decode helpers used by the controller.
package mem_access_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IND_RD,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_LD  = 2'b00,
        MODE_ST  = 2'b01,
        MODE_LDI = 2'b10,
        MODE_STI = 2'b11
    } mode_e;

    // Bit 1 selects a pointer fetch, bit 0 selects a write.
    function automatic logic is_indirect(input mode_e m);
        return m[1];
    endfunction

    function automatic logic is_load(input mode_e m);
        return !m[0];
    endfunction

    function automatic logic is_access(input state_e s);
        return (s == ST_IND_RD) || (s == ST_DATA_RD) || (s == ST_DATA_WR);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Memory-side bus of the access controller: address/data, read/write
// strobes and the single-cycle completion acknowledge.
interface mem_access_if;
    import mem_access_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_din, mem_rd, mem_wr,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_addr, mem_din, mem_rd, mem_wr,
        output mem_dout, mem_ack
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive un-acknowledged cycles of one memory access and flags
// the cycle in which the WAIT_MAX-th such cycle occurs.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The current tick is the last one allowed when WAIT_MAX-1 are already counted.
    assign expired = tick && (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LD/ST/LDI/STI memory access sequencer with registered bus outputs.
// Optional access timeout is built when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] memout,
    output logic              enable_writeback,
    output logic              busy,
    output logic              done,
    output logic              err,
    mem_access_if.master      mem
);

    if (WAIT_MAX < 1) begin : g_wait_max_check
        $error("mem_access_ctrl: WAIT_MAX must be at least 1");
    end

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] memout_q, memout_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic              wb_q, wb_d;
    logic              expired;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic timer_tick;
    logic timer_clr;

    // Any state change restarts the count, so each access state begins at zero.
    assign timer_tick = is_access(state_q) && !mem.mem_ack;
    assign timer_clr  = (state_d != state_q);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .tick    (timer_tick),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        memout_d = memout_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode_e'(mode);
                    addr_d = addr_in;
                    data_d = data_in;
                    err_d  = 1'b0;
                    if (is_indirect(mode_e'(mode))) begin
                        state_d = ST_IND_RD;
                    end else if (is_load(mode_e'(mode))) begin
                        state_d = ST_DATA_RD;
                    end else begin
                        state_d = ST_DATA_WR;
                    end
                end
            end
            ST_IND_RD: begin
                if (mem.mem_ack) begin
                    ptr_d   = mem.mem_dout;
                    state_d = is_load(mode_q) ? ST_DATA_RD : ST_DATA_WR;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DATA_RD: begin
                if (mem.mem_ack) begin
                    memout_d = mem.mem_dout;
                    state_d  = ST_DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DATA_WR: begin
                if (mem.mem_ack) begin
                    state_d = ST_DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they are registered.
        mem_rd_d   = (state_d == ST_IND_RD) || (state_d == ST_DATA_RD);
        mem_wr_d   = (state_d == ST_DATA_WR);
        done_d     = (state_d == ST_DONE);
        wb_d       = done_d && is_load(mode_q) && !err_d;
        mem_addr_d = addr_d;
        if (((state_d == ST_DATA_RD) || (state_d == ST_DATA_WR)) && is_indirect(mode_d)) begin
            mem_addr_d = ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_LD;
            addr_q     <= '0;
            data_q     <= '0;
            ptr_q      <= '0;
            memout_q   <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            wb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ptr_q      <= ptr_d;
            memout_q   <= memout_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            wb_q       <= wb_d;
        end
    end

    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_din      = data_q;
    assign mem.mem_rd       = mem_rd_q;
    assign mem.mem_wr       = mem_wr_q;
    assign memout           = memout_q;
    assign enable_writeback = wb_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of complete accesses
// plus hand-written reset, back-to-back and wait/timeout sequences.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] memout;
    logic        enable_writeback;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_access_if mem_if ();

    mem_access_ctrl #(
        .WAIT_MAX (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .addr_in          (addr_in),
        .data_in          (data_in),
        .memout           (memout),
        .enable_writeback (enable_writeback),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .mem              (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ptr;
        logic [15:0] rdata;
        int          wait_ind;
        int          wait_data;
        logic [15:0] exp_daddr;
        logic [15:0] exp_memout;
        logic        exp_wb;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic is_wr;

        // mode, addr, wdata, ptr, rdata, wait_ind, wait_data, exp_daddr, exp_memout, exp_wb, exp_lat
        vecs[0] = '{MODE_LD,  16'h3000, 16'h0000, 16'h0000, 16'h1234, 0, 0, 16'h3000, 16'h1234, 1'b1, 2};
        vecs[1] = '{MODE_STI, 16'h3001, 16'hBEEF, 16'h4000, 16'hF00D, 0, 3, 16'h4000, 16'h1234, 1'b0, 6};
        vecs[2] = '{MODE_LDI, 16'h3000, 16'h0000, 16'h5000, 16'h00FF, 0, 0, 16'h5000, 16'h00FF, 1'b1, 3};
        vecs[3] = '{MODE_ST,  16'h2222, 16'hA5A5, 16'h0000, 16'hF00D, 0, 1, 16'h2222, 16'h00FF, 1'b0, 3};
        vecs[4] = '{MODE_LD,  16'hFFFF, 16'h0000, 16'h0000, 16'h8001, 0, 2, 16'hFFFF, 16'h8001, 1'b1, 4};
        vecs[5] = '{MODE_LDI, 16'h0010, 16'h0000, 16'h0020, 16'h7E7E, 2, 1, 16'h0020, 16'h7E7E, 1'b1, 6};

        rst = 1'b1;
        start = 1'b1;
        mode = MODE_LD;
        addr_in = 16'h1111;
        data_in = 16'h2222;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_dout = 16'h0000;

        // Held reset overrides a pending start.
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rd", mem_if.mem_rd, 1'b0);
        chk("rst_mem_wr", mem_if.mem_wr, 1'b0);
        chk("rst_mem_addr", mem_if.mem_addr, 16'h0000);
        chk("rst_mem_din", mem_if.mem_din, 16'h0000);
        chk("rst_memout", memout, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_wb", enable_writeback, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            is_wr = vecs[i].mode[0];
            start = 1'b1;
            mode = vecs[i].mode;
            addr_in = vecs[i].addr;
            data_in = vecs[i].wdata;
            step();
            start = 1'b0;
            cyc = 1;
            if (vecs[i].mode[1]) begin
                for (int w = 0; w <= vecs[i].wait_ind; w++) begin
                    chk($sformatf("v%0d_ind_rd", i), mem_if.mem_rd, 1'b1);
                    chk($sformatf("v%0d_ind_wr", i), mem_if.mem_wr, 1'b0);
                    chk($sformatf("v%0d_ind_addr", i), mem_if.mem_addr, vecs[i].addr);
                    mem_if.mem_ack = (w == vecs[i].wait_ind);
                    mem_if.mem_dout = (w == vecs[i].wait_ind) ? vecs[i].ptr : 16'hDEAD;
                    step();
                    cyc++;
                end
            end
            for (int w = 0; w <= vecs[i].wait_data; w++) begin
                chk($sformatf("v%0d_data_rd", i), mem_if.mem_rd, !is_wr);
                chk($sformatf("v%0d_data_wr", i), mem_if.mem_wr, is_wr);
                chk($sformatf("v%0d_data_addr", i), mem_if.mem_addr, vecs[i].exp_daddr);
                if (is_wr) chk($sformatf("v%0d_data_din", i), mem_if.mem_din, vecs[i].wdata);
                chk($sformatf("v%0d_data_done", i), done, 1'b0);
                mem_if.mem_ack = (w == vecs[i].wait_data);
                mem_if.mem_dout = (w == vecs[i].wait_data) ? vecs[i].rdata : 16'hDEAD;
                step();
                cyc++;
            end
            mem_if.mem_ack = 1'b0;
            mem_if.mem_dout = 16'h0000;
            chk($sformatf("v%0d_done", i), done, 1'b1);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
            chk($sformatf("v%0d_wb", i), enable_writeback, vecs[i].exp_wb);
            chk($sformatf("v%0d_memout", i), memout, vecs[i].exp_memout);
            chk($sformatf("v%0d_strobes_off", i), {mem_if.mem_rd, mem_if.mem_wr}, 2'b00);
            step();
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
            chk($sformatf("v%0d_wb_pulse", i), enable_writeback, 1'b0);
            chk($sformatf("v%0d_idle", i), busy, 1'b0);
            chk($sformatf("v%0d_memout_hold", i), memout, vecs[i].exp_memout);
        end

        // Acknowledge outside an access is ignored.
        mem_if.mem_ack = 1'b1;
        mem_if.mem_dout = 16'hDEAD;
        step();
        mem_if.mem_ack = 1'b0;
        chk("stray_ack_busy", busy, 1'b0);
        chk("stray_ack_done", done, 1'b0);
        chk("stray_ack_memout", memout, 16'h7E7E);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Never acknowledged: times out after 15 wait cycles.
        start = 1'b1;
        mode = MODE_LD;
        addr_in = 16'h0ABC;
        step();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("to_wait%0d_done", k), done, 1'b0);
            step();
        end
        chk("to_done", done, 1'b1);
        chk("to_err", err, 1'b1);
        chk("to_wb", enable_writeback, 1'b0);
        chk("to_memout", memout, 16'h7E7E);
        step();
        chk("to_idle", busy, 1'b0);
        chk("to_err_held", err, 1'b1);
        start = 1'b1;
        mode = MODE_ST;
        addr_in = 16'h0100;
        data_in = 16'h5555;
        step();
        start = 1'b0;
        chk("to_err_cleared", err, 1'b0);
        chk("to_next_wr", mem_if.mem_wr, 1'b1);
        mem_if.mem_ack = 1'b1;
        step();
        mem_if.mem_ack = 1'b0;
        chk("to_next_done", done, 1'b1);
        step();
`else
        // Without the timeout the access waits as long as needed.
        start = 1'b1;
        mode = MODE_LD;
        addr_in = 16'h0ABC;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("nt_busy", busy, 1'b1);
        chk("nt_rd", mem_if.mem_rd, 1'b1);
        chk("nt_done", done, 1'b0);
        chk("nt_err", err, 1'b0);
        mem_if.mem_ack = 1'b1;
        mem_if.mem_dout = 16'h1357;
        step();
        mem_if.mem_ack = 1'b0;
        chk("nt_late_done", done, 1'b1);
        chk("nt_late_memout", memout, 16'h1357);
        step();
`endif

        // Reset in the middle of a waiting load.
        start = 1'b1;
        mode = MODE_LD;
        addr_in = 16'h4444;
        step();
        start = 1'b0;
        step();
        chk("mid_rd", mem_if.mem_rd, 1'b1);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd", mem_if.mem_rd, 1'b0);
        chk("mid_rst_addr", mem_if.mem_addr, 16'h0000);
        chk("mid_rst_din", mem_if.mem_din, 16'h0000);
        chk("mid_rst_memout", memout, 16'h0000);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_wb", enable_writeback, 1'b0);
        chk("mid_rst_err", err, 1'b0);

        // Start held through a whole access is only taken again from IDLE.
        start = 1'b1;
        mode = MODE_LD;
        addr_in = 16'h1000;
        step();
        mode = MODE_ST;
        addr_in = 16'h2000;
        data_in = 16'h6060;
        chk("hold_addr", mem_if.mem_addr, 16'h1000);
        chk("hold_rd", mem_if.mem_rd, 1'b1);
        mem_if.mem_ack = 1'b1;
        mem_if.mem_dout = 16'h0BAD;
        step();
        mem_if.mem_ack = 1'b0;
        chk("hold_done", done, 1'b1);
        chk("hold_wb", enable_writeback, 1'b1);
        chk("hold_memout", memout, 16'h0BAD);
        step();
        chk("hold_idle_busy", busy, 1'b0);
        chk("hold_idle_wr", mem_if.mem_wr, 1'b0);
        step();
        start = 1'b0;
        chk("b2b_wr", mem_if.mem_wr, 1'b1);
        chk("b2b_addr", mem_if.mem_addr, 16'h2000);
        chk("b2b_din", mem_if.mem_din, 16'h6060);
        mem_if.mem_ack = 1'b1;
        step();
        mem_if.mem_ack = 1'b0;
        chk("b2b_done", done, 1'b1);
        chk("b2b_wb", enable_writeback, 1'b0);
        chk("b2b_memout", memout, 16'h0BAD);
        step();
        chk("b2b_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
